// File: rtl/cpu_ad48_muldiv.sv
// Iterative radix-2 multiply/divide unit for the cpu_ad48 execute stage.
// MUL/MULH use shift-add and DIV/REM use restoring division on magnitudes; the sign is applied in FIX.
module cpu_ad48_muldiv #(
    parameter int WIDTH = 48,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_dz,
    input  logic             flush,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_REM  = 2'd3;

    state_t               state_r, state_s;
    logic [1:0]           op_r;
    logic                 neg_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [WIDTH-1:0]     result_r;
    logic                 dz_r;

    logic                 accept_s;
    logic                 div_zero_s;
    logic                 a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_abs_s, b_abs_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH:0]       div_trial_s;
    logic [WIDTH:0]       div_diff_s;
    logic                 div_ge_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     fix_s;

    assign accept_s   = req_valid & (state_r == S_IDLE);
    assign div_zero_s = req_op[1] & (req_b == {WIDTH{1'b0}});
    assign a_neg_s    = req_signed & req_a[WIDTH-1];
    assign b_neg_s    = req_signed & req_b[WIDTH-1];
    assign a_abs_s    = a_neg_s ? -req_a : req_a;
    assign b_abs_s    = b_neg_s ? -req_b : req_b;

    // One iteration of shift-add (multiply) and restoring shift-subtract (divide)
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_diff_s  = div_trial_s - {1'b0, opnd_r};
        div_ge_s    = (div_trial_s >= {1'b0, opnd_r});
        div_next_s  = {(div_ge_s ? div_diff_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0]),
                       acc_r[WIDTH-2:0], div_ge_s};
    end

    // Final result selection with sign correction; the full product is negated before MULH picks its half
    always_comb begin
        prod_s = neg_r ? -acc_r : acc_r;
        fix_s  = {WIDTH{1'b0}};
        case (op_r)
            OP_MUL:  fix_s = prod_s[WIDTH-1:0];
            OP_MULH: fix_s = prod_s[2*WIDTH-1:WIDTH];
            OP_DIV:  fix_s = neg_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
            OP_REM:  fix_s = neg_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
            default: fix_s = {WIDTH{1'b0}};
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush overrides accept and the response handshake
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_s = div_zero_s ? S_DONE : S_RUN;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_s = S_FIX;
                    end else begin
                        state_s = S_RUN;
                    end
                end
                S_FIX:   state_s = S_DONE;
                S_DONE: begin
                    if (resp_ready) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_DONE;
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Operand capture, iteration datapath and held result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r     <= 2'd0;
            neg_r    <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            dz_r     <= 1'b0;
        end else if (flush) begin
            result_r <= {WIDTH{1'b0}};
            dz_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r   <= req_op;
                        neg_r  <= (req_op == OP_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
                        cnt_r  <= CNT_W'(WIDTH - 1);
                        acc_r  <= {{WIDTH{1'b0}}, (req_op[1] ? a_abs_s : b_abs_s)};
                        opnd_r <= req_op[1] ? b_abs_s : a_abs_s;
                        if (div_zero_s) begin
                            result_r <= (req_op == OP_DIV) ? {WIDTH{1'b1}} : req_a;
                            dz_r     <= 1'b1;
                        end else begin
                            dz_r     <= 1'b0;
                        end
                    end else begin
                        dz_r <= dz_r;
                    end
                end
                S_RUN: begin
                    acc_r <= op_r[1] ? div_next_s : mul_next_s;
                    cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
                S_FIX: begin
                    result_r <= fix_s;
                    dz_r     <= 1'b0;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        result_r <= {WIDTH{1'b0}};
                        dz_r     <= 1'b0;
                    end else begin
                        result_r <= result_r;
                    end
                end
                default: begin
                    result_r <= {WIDTH{1'b0}};
                    dz_r     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = (state_r == S_IDLE);
    assign busy        = (state_r != S_IDLE);
    assign resp_valid  = (state_r == S_DONE);
    assign resp_result = result_r;
    assign resp_dz     = dz_r;

endmodule

// File: tb/tb_cpu_ad48_muldiv.sv
// Self-checking bench for cpu_ad48_muldiv: WIDTH=48 and WIDTH=16 instances against a wide-arithmetic reference model.
module tb_cpu_ad48_muldiv;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid48 = 1'b0, req_valid16 = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] a_v = 64'd0, b_v = 64'd0;
    logic        resp_ready = 1'b1;
    logic        flush = 1'b0;
    logic        sel16 = 1'b0;

    logic        ready48, rv48, dz48, busy48;
    logic [47:0] res48;
    logic        ready16, rv16, dz16, busy16;
    logic [15:0] res16;

    logic        cur_ready, cur_rv, cur_dz, cur_busy;
    logic [63:0] cur_res;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_ad48_muldiv #(.WIDTH(48)) dut48 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid48), .req_ready(ready48),
        .req_op(req_op), .req_signed(req_signed), .req_a(a_v[47:0]), .req_b(b_v[47:0]),
        .resp_valid(rv48), .resp_ready(resp_ready), .resp_result(res48), .resp_dz(dz48),
        .flush(flush), .busy(busy48)
    );

    cpu_ad48_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid16), .req_ready(ready16),
        .req_op(req_op), .req_signed(req_signed), .req_a(a_v[15:0]), .req_b(b_v[15:0]),
        .resp_valid(rv16), .resp_ready(resp_ready), .resp_result(res16), .resp_dz(dz16),
        .flush(flush), .busy(busy16)
    );

    assign cur_ready = sel16 ? ready16 : ready48;
    assign cur_rv    = sel16 ? rv16 : rv48;
    assign cur_dz    = sel16 ? dz16 : dz48;
    assign cur_busy  = sel16 ? busy16 : busy48;
    assign cur_res   = sel16 ? {48'd0, res16} : {16'd0, res48};

    // Reference: exact wide signed arithmetic; SV / and % truncate toward zero like the spec asks
    function automatic void model(input int w, input logic [1:0] op, input logic sgn,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res, output logic dz);
        logic signed [127:0] av, bv, p, q, r;
        logic [127:0] mask;
        mask = (128'd1 << w) - 128'd1;
        av = $signed({64'd0, a});
        bv = $signed({64'd0, b});
        if (sgn && a[w-1]) av = av - (128'sd1 <<< w);
        if (sgn && b[w-1]) bv = bv - (128'sd1 <<< w);
        dz = 1'b0;
        res = 64'd0;
        if (op[1] && b == 64'd0) begin
            dz = 1'b1;
            res = (op == 2'd2) ? 64'(mask) : a;
        end else begin
            p = av * bv;
            case (op)
                2'd0: res = 64'(p & mask);
                2'd1: res = 64'((p >>> w) & mask);
                2'd2: begin q = av / bv; res = 64'(q & mask); end
                default: begin r = av % bv; res = 64'(r & mask); end
            endcase
        end
    endfunction

    function automatic logic [63:0] rnd_opnd(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 6))
            0: rnd_opnd = 64'd0;
            1: rnd_opnd = 64'd1;
            2: rnd_opnd = m;
            3: rnd_opnd = 64'd1 << (w - 1);
            4: rnd_opnd = 64'($urandom_range(0, 20));
            default: rnd_opnd = {$urandom, $urandom} & m;
        endcase
    endfunction

    // Issue one request on the selected instance and wait for its response; lat counts edges after accept
    task automatic do_op(input int w, input logic [1:0] op, input logic sgn,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output logic dz, output int lat, output int acc_cyc);
        int guard;
        sel16 = (w == 16);
        @(negedge clk);
        guard = 0;
        while (!cur_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        req_op = op; req_signed = sgn; a_v = a; b_v = b;
        if (w == 16) req_valid16 = 1'b1; else req_valid48 = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        req_valid16 = 1'b0; req_valid48 = 1'b0;
        lat = 0;
        while (!cur_rv && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!cur_rv) lat = 999;
        res = cur_res;
        dz = cur_dz;
    endtask

    task automatic test_reset();
        sel16 = 1'b0;
        checks++;
        if (ready48 !== 1'b1 || rv48 !== 1'b0 || res48 !== 48'd0 || dz48 !== 1'b0 || busy48 !== 1'b0) begin
            failures++;
            $display("FAIL reset48 ready=%b rv=%b res=%h dz=%b busy=%b required 1 0 0 0 0", ready48, rv48, res48, dz48, busy48);
        end
        checks++;
        if (ready16 !== 1'b1 || rv16 !== 1'b0 || res16 !== 16'd0 || dz16 !== 1'b0 || busy16 !== 1'b0) begin
            failures++;
            $display("FAIL reset16 ready=%b rv=%b res=%h dz=%b busy=%b required 1 0 0 0 0", ready16, rv16, res16, dz16, busy16);
        end
    endtask

    typedef struct {
        int          w;
        logic [1:0]  op;
        logic        sgn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        edz;
    } dir_t;

    task automatic test_directed();
        dir_t tbl [0:18];
        logic [63:0] res;
        logic dz;
        int lat, ac, elat;
        tbl = '{
            '{48, 2'd0, 1'b0, 64'd7, 64'd5, 64'd35, 1'b0},
            '{48, 2'd1, 1'b0, 64'd7, 64'd5, 64'd0, 1'b0},
            '{48, 2'd1, 1'b1, 64'h0000_FFFF_FFFF_FFFE, 64'd3, 64'h0000_FFFF_FFFF_FFFF, 1'b0},
            '{48, 2'd0, 1'b1, 64'h0000_FFFF_FFFF_FFFE, 64'd3, 64'h0000_FFFF_FFFF_FFFA, 1'b0},
            '{48, 2'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0},
            '{48, 2'd2, 1'b1, 64'h0000_FFFF_FFFF_FFF9, 64'd2, 64'h0000_FFFF_FFFF_FFFD, 1'b0},
            '{48, 2'd3, 1'b1, 64'h0000_FFFF_FFFF_FFF9, 64'd2, 64'h0000_FFFF_FFFF_FFFF, 1'b0},
            '{48, 2'd2, 1'b0, 64'h0000_FFFF_FFFF_FFF9, 64'd2, 64'h0000_7FFF_FFFF_FFFC, 1'b0},
            '{48, 2'd2, 1'b1, 64'h0000_8000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 64'h0000_8000_0000_0000, 1'b0},
            '{48, 2'd3, 1'b1, 64'h0000_8000_0000_0000, 64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b0},
            '{48, 2'd2, 1'b1, 64'd123, 64'd0, 64'h0000_FFFF_FFFF_FFFF, 1'b1},
            '{48, 2'd3, 1'b1, 64'd123, 64'd0, 64'd123, 1'b1},
            '{16, 2'd2, 1'b1, 64'hFFF9, 64'd2, 64'hFFFD, 1'b0},
            '{16, 2'd3, 1'b1, 64'hFFF9, 64'd2, 64'hFFFF, 1'b0},
            '{16, 2'd0, 1'b1, 64'hFFFE, 64'd3, 64'hFFFA, 1'b0},
            '{16, 2'd1, 1'b1, 64'hFFFE, 64'd3, 64'hFFFF, 1'b0},
            '{16, 2'd2, 1'b1, 64'h8000, 64'hFFFF, 64'h8000, 1'b0},
            '{16, 2'd0, 1'b0, 64'd7, 64'd5, 64'd35, 1'b0},
            '{16, 2'd2, 1'b0, 64'd123, 64'd0, 64'hFFFF, 1'b1}
        };
        for (int i = 0; i < 19; i++) begin
            do_op(tbl[i].w, tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b, res, dz, lat, ac);
            elat = tbl[i].edz ? 0 : tbl[i].w + 1;
            checks++;
            if (res !== tbl[i].exp || dz !== tbl[i].edz || lat != elat) begin
                failures++;
                $display("FAIL directed[%0d] res=%h dz=%b lat=%0d required res=%h dz=%b lat=%0d",
                         i, res, dz, lat, tbl[i].exp, tbl[i].edz, elat);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, res, exp;
        logic dz, edz, sgn;
        logic [1:0] op;
        int lat, ac, w, elat;
        for (int i = 0; i < 60; i++) begin
            w = (i % 2 == 0) ? 48 : 16;
            op = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            a = rnd_opnd(w);
            b = rnd_opnd(w);
            model(w, op, sgn, a, b, exp, edz);
            do_op(w, op, sgn, a, b, res, dz, lat, ac);
            elat = edz ? 0 : w + 1;
            checks++;
            if (res !== exp || dz !== edz || lat != elat) begin
                failures++;
                $display("FAIL random[%0d] w=%0d op=%0d s=%b a=%h b=%h res=%h dz=%b lat=%0d required %h %b %0d",
                         i, w, op, sgn, a, b, res, dz, lat, exp, edz, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        logic dz;
        int lat, ac0, ac1;
        for (int k = 0; k < 2; k++) begin
            do_op(k == 0 ? 48 : 16, 2'd0, 1'b0, 64'd9, 64'd9, res, dz, lat, ac0);
            do_op(k == 0 ? 48 : 16, 2'd2, 1'b0, 64'd81, 64'd9, res, dz, lat, ac1);
            checks++;
            if (ac1 - ac0 != (k == 0 ? 51 : 19) || res !== 64'd9) begin
                failures++;
                $display("FAIL back_to_back k=%0d interval=%0d res=%h required %0d %h",
                         k, ac1 - ac0, res, k == 0 ? 51 : 19, 64'd9);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] res;
        logic dz;
        int lat, ac, bad;
        resp_ready = 1'b0;
        do_op(48, 2'd0, 1'b0, 64'd6, 64'd7, res, dz, lat, ac);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rv48 !== 1'b1 || ready48 !== 1'b0 || res48 !== 48'd42 || dz48 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || res !== 64'd42) begin
            failures++;
            $display("FAIL backpressure_hold bad_cycles=%0d res=%h required 0 and 42", bad, res);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rv48 !== 1'b0 || ready48 !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release rv=%b ready=%b required 0 1", rv48, ready48);
        end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        logic dz;
        int lat, ac, seen;
        sel16 = 1'b0;
        @(negedge clk);
        req_op = 2'd0; req_signed = 1'b0; a_v = 64'd1000; b_v = 64'd1000; req_valid48 = 1'b1;
        @(posedge clk); #1;
        req_valid48 = 1'b0;
        for (int i = 0; i < 19; i++) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy48 !== 1'b0 || rv48 !== 1'b0 || ready48 !== 1'b1) begin
            failures++;
            $display("FAIL flush_run busy=%b rv=%b ready=%b required 0 0 1", busy48, rv48, ready48);
        end
        @(negedge clk);
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (rv48 === 1'b1 || busy48 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_no_resp active_cycles=%0d required 0", seen);
        end
        @(negedge clk);
        req_valid48 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy48 !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle busy=%b required 0", busy48);
        end
        @(negedge clk);
        req_valid48 = 1'b0; flush = 1'b0;
        resp_ready = 1'b0;
        do_op(48, 2'd2, 1'b0, 64'd5, 64'd0, res, dz, lat, ac);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rv48 !== 1'b0 || dz48 !== 1'b0 || res48 !== 48'd0 || ready48 !== 1'b1) begin
            failures++;
            $display("FAIL flush_done rv=%b dz=%b res=%h ready=%b required 0 0 0 1", rv48, dz48, res48, ready48);
        end
        @(negedge clk);
        flush = 1'b0; resp_ready = 1'b1;
        do_op(48, 2'd0, 1'b0, 64'd3, 64'd4, res, dz, lat, ac);
        checks++;
        if (res !== 64'd12 || lat != 49) begin
            failures++;
            $display("FAIL flush_after res=%h lat=%0d required 12 49", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        logic dz;
        int lat, ac;
        sel16 = 1'b0;
        @(negedge clk);
        req_op = 2'd2; req_signed = 1'b1; a_v = 64'd77; b_v = 64'd5; req_valid48 = 1'b1;
        @(posedge clk); #1;
        req_valid48 = 1'b0;
        for (int i = 0; i < 10; i++) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (rv48 !== 1'b0 || res48 !== 48'd0 || dz48 !== 1'b0 || busy48 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid rv=%b res=%h dz=%b busy=%b required 0 0 0 0", rv48, res48, dz48, busy48);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready48 !== 1'b1 || rv48 !== 1'b0 || busy48 !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ready=%b rv=%b busy=%b required 1 0 0", ready48, rv48, busy48);
        end
        do_op(48, 2'd3, 1'b1, 64'd77, 64'd5, res, dz, lat, ac);
        checks++;
        if (res !== 64'd2 || lat != 49) begin
            failures++;
            $display("FAIL reset_after res=%h lat=%0d required 2 49", res, lat);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
